seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised execute-stage ALU for the RV32I core with an XLEN-bit datapath, a valid/ready handshake on input and output, and a registered result. Base integer ops complete in one cycle. Multiply-high and divide/remainder run on an iterative shift-add / restoring-division engine in XLEN steps. It succeeds the purely combinational `alu` in the execute stage and lets the core stall on long-latency M-extension ops.

## Interface
- XLEN, default 32: datapath width; power of two, ≥ 8.
- SHW, default $clog2(XLEN): shift-amount width, derived.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous abort; drops any in-flight op and any held result.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block accepts an op this cycle.
- r1  in  XLEN  operand A.
- r2  in  XLEN  operand B; shifts use r2[SHW-1:0] only.
- alu_control  in  4  opcode.
- out_valid  out  1  alu_result holds a completed result.
- out_ready  in  1  consumer takes the result this cycle.
- alu_result  out  XLEN  registered result.
- busy  out  1  iterative engine running.

## Operation
- Opcodes, single-cycle:
  - 0000 ADD; 0001 SLL; 0010 SLT (signed); 0011 SLTU; 0100 XOR.
  - 0101 SRL; 0110 OR; 0111 AND; 1000 SUB; 1001 SRA.
  - SLT/SLTU results are zero-extended 0/1.
  - Add/sub wrap modulo 2^XLEN.
- Opcodes, iterative:
  - 1010 MUL: low XLEN bits of the product.
  - 1011 MULHU: high XLEN bits of the unsigned 2·XLEN product.
  - 1100 DIV; 1101 DIVU; 1110 REM; 1111 REMU.
- Signed division:
  - Divide operand magnitudes unsigned, then negate on write.
  - Quotient is negated when the operand signs differ; remainder takes the sign of the dividend.
  - MIN / −1 yields quotient MIN, remainder 0, with no special case.
- Divide by zero (r2 == 0, any of 1100–1111) completes as a single-cycle op:
  - Quotient is all ones.
  - Remainder is r1 unmodified.
- Handshake:
  - Accept on clk edge when in_valid && in_ready.
  - in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush.
  - On out_valid && out_ready, out_valid clears unless a new result is written on the same edge.
- FSM states: IDLE, BUSY.
  - IDLE→BUSY: iterative op accepted with r2 ≠ 0 (or MUL/MULHU). The op's operands, opcode and sign flags are latched, and the step counter is loaded with XLEN.
  - BUSY: one step per edge; the counter decrements.
  - BUSY→IDLE: on the edge the counter goes 1→0. That edge writes alu_result (sign fix applied) and sets out_valid.
  - BUSY never starts while out_valid is held, because in_ready gates entry.
- busy = (state == BUSY).
- flush:
  - Forces IDLE and clears out_valid and the counter.
  - alu_result keeps its value.
  - An op presented in the flush cycle is not accepted.
- Reset (asynchronous, any state including mid-BUSY):
  - state = IDLE; out_valid = 0; alu_result = 0; counter = 0; busy = 0.
  - in_ready = 1 once rst deasserts.

## Timing
- Single-cycle op (including divide by zero): accepted on edge E0; result and out_valid visible after E0. Latency 1.
- Iterative op: accepted on E0; steps on E1…E_XLEN; result and out_valid visible after E_XLEN. Latency XLEN+1, i.e. 33 at XLEN = 32.
- Throughput:
  - Single-cycle ops: 1 per cycle when out_ready is held high.
  - Iterative ops: one per XLEN+1 cycles.
- Back-pressure: while out_valid && !out_ready, alu_result and out_valid are stable and in_ready = 0.
- in_valid is ignored in BUSY. The source holds its op until in_ready.

## Test plan
- Reset, then ADD r1 = 30, r2 = 15 with out_ready = 1 → alu_result = 45, out_valid one cycle after acceptance. Follow back-to-back with SLL 16,1 → 32, then SLT 15,30 → 1. Each accepted on consecutive cycles.
- SRA 0x80000000, 4 → 0xF8000000. SRL same operands → 0x08000000. SUB 15,30 → 0xFFFFFFF1. SLTU 1, 0xFFFFFFFF → 1.
- MUL 0x00010000 × 0x00010000 → 0x00000000. MULHU same → 0x00000001. out_valid exactly 33 cycles after acceptance, busy high for 32 cycles, in_ready low throughout.
- Division cases:
  - DIV −7, 2 → 0xFFFFFFFD; REM −7, 2 → 0xFFFFFFFF.
  - DIV 0x80000000, 0xFFFFFFFF → 0x80000000; REM same → 0.
  - DIVU 10, 0 → 0xFFFFFFFF; REMU 10, 0 → 10, both with latency 1.
- Back-pressure: hold out_ready = 0 after ADD 1,2 → result 3 held stable for 5 cycles, in_ready = 0. Release → result taken and a queued op accepted on the same edge.
- Abort cases:
  - Assert flush at cycle 10 of a DIVU → busy and out_valid drop next edge, in_ready = 1, no result produced.
  - Repeat with rst asserted mid-BUSY → all outputs reset immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: execute-stage ALU with valid/ready handshake, registered result,
// single-cycle base ops and an iterative shift-add / restoring-divide engine.
module seq_alu #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] r2,
  input  logic [3:0]      alu_control,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SLL   = 4'b0001;
  localparam logic [3:0] OP_SLT   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_SUB   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIV   = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_REM   = 4'b1110;
  localparam logic [3:0] OP_REMU  = 4'b1111;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e          state_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] hi_q, lo_q, opb_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      op_q;
  logic            neg_q;

  logic            accept;
  logic            div0;
  logic            iter_start;
  logic [XLEN-1:0] sc_result_d;
  logic            signed_div;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            neg_d;
  logic [XLEN-1:0] lo_start_d, opb_start_d;

  logic            is_mul;
  logic            take_hi;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] hi_d, lo_d;
  logic [XLEN-1:0] raw_d, fin_d;

  // Handshake and status outputs
  assign in_ready   = (state_q == S_IDLE) && (!out_valid_q || out_ready) && !flush;
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign alu_result = result_q;
  assign busy       = (state_q == S_BUSY);

  // Divide-by-zero resolves immediately; other M ops go to the engine
  assign div0       = (alu_control[3:2] == 2'b11) && (r2 == '0);
  assign iter_start = (alu_control >= OP_MUL) && !div0;

  // Single-cycle result, including the divide-by-zero outcomes
  always_comb begin
    sc_result_d = '0;
    case (alu_control)
      OP_ADD:  sc_result_d = r1 + r2;
      OP_SLL:  sc_result_d = r1 << r2[SHW-1:0];
      OP_SLT:  sc_result_d = {{(XLEN-1){1'b0}}, ($signed(r1) < $signed(r2))};
      OP_SLTU: sc_result_d = {{(XLEN-1){1'b0}}, (r1 < r2)};
      OP_XOR:  sc_result_d = r1 ^ r2;
      OP_SRL:  sc_result_d = r1 >> r2[SHW-1:0];
      OP_OR:   sc_result_d = r1 | r2;
      OP_AND:  sc_result_d = r1 & r2;
      OP_SUB:  sc_result_d = r1 - r2;
      OP_SRA:  sc_result_d = $unsigned($signed(r1) >>> r2[SHW-1:0]);
      OP_DIV,
      OP_DIVU: sc_result_d = '1;
      OP_REM,
      OP_REMU: sc_result_d = r1;
      default: sc_result_d = '0;
    endcase
  end

  // Engine load values: operand magnitudes and the deferred sign fix
  always_comb begin
    signed_div  = (alu_control == OP_DIV) || (alu_control == OP_REM);
    a_mag       = (signed_div && r1[XLEN-1]) ? ('0 - r1) : r1;
    b_mag       = (signed_div && r2[XLEN-1]) ? ('0 - r2) : r2;
    neg_d       = 1'b0;
    if (alu_control == OP_DIV) neg_d = r1[XLEN-1] ^ r2[XLEN-1];
    if (alu_control == OP_REM) neg_d = r1[XLEN-1];
    lo_start_d  = (alu_control[3:1] == 3'b101) ? r2 : a_mag;
    opb_start_d = (alu_control[3:1] == 3'b101) ? r1 : b_mag;
  end

  // One engine step: shift-add multiply or restoring divide on {hi, lo}
  always_comb begin
    is_mul    = (op_q[3:1] == 3'b101);
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ge    = !div_diff[XLEN];
    if (is_mul) begin
      hi_d = mul_sum[XLEN:1];
      lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
    end else begin
      hi_d = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], div_ge};
    end
    take_hi = (op_q == OP_MULHU) || (op_q == OP_REM) || (op_q == OP_REMU);
    raw_d   = take_hi ? hi_d : lo_d;
    fin_d   = neg_q ? ('0 - raw_d) : raw_d;
  end

  // Control FSM, engine registers and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opb_q       <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (iter_start) begin
              state_q <= S_BUSY;
              cnt_q   <= CW'(XLEN);
              op_q    <= alu_control;
              neg_q   <= neg_d;
              hi_q    <= '0;
              lo_q    <= lo_start_d;
              opb_q   <= opb_start_d;
            end else begin
              result_q    <= sc_result_d;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= S_IDLE;
            result_q    <= fin_d;
            out_valid_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed bench for seq_alu with an arithmetic reference model
// and a scoreboard that checks every presented result.
module tb_seq_alu;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] r1;
  logic [XLEN-1:0] r2;
  logic [3:0]      alu_control;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result;
  logic            busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  seq_alu #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .r1          (r1),
    .r2          (r2),
    .alu_control (alu_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_result  (alu_result),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: RV32I/M semantics in plain wide arithmetic
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    logic [4:0]  sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = {32'd0, a} * {32'd0, b};
    sh = b[4:0];
    case (op)
      4'd0:  return a + b;
      4'd1:  return a << sh;
      4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd3:  return (a < b) ? 32'd1 : 32'd0;
      4'd4:  return a ^ b;
      4'd5:  return a >> sh;
      4'd6:  return a | b;
      4'd7:  return a & b;
      4'd8:  return a - b;
      4'd9:  return 32'(sa >>> sh);
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      4'd12: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14: return (b == 0) ? a : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Scoreboard bookkeeping at the active edge
  always @(posedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) exp_q.push_back(model(alu_control, r1, r2));
    end
  end

  // Compare every presented result against the model
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got result 0x%08h with no op outstanding", alu_result);
      end else begin
        check("sb_result", alu_result, exp_q[0]);
      end
    end
  end

  // Issue one op (called at a negedge), wait for its result; checks latency and busy
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int guard, lat, nbusy;
    logic inr_bad;
    check({name, "_model"}, model(op, a, b), exp);
    in_valid = 1'b1; alu_control = op; r1 = a; r2 = b;
    #1;
    guard = 0;
    while (!in_ready && guard < 100) begin @(negedge clk); #1; guard++; end
    if (guard >= 100) begin
      checks++; errors++;
      $display("FAIL %s_accept: got no acceptance expected acceptance within 100 cycles", name);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1; nbusy = 0; inr_bad = 1'b0;
    while (!out_valid && lat < 100) begin
      if (busy) nbusy++;
      if (in_ready) inr_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({name, "_result"}, alu_result, exp);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_busy_cycles"}, 32'(nbusy), (exp_lat == 33) ? 32'd32 : 32'd0);
    check({name, "_in_ready_low"}, {31'd0, inr_bad}, 32'd0);
  endtask

  // Issue one op and wait for it, relying on the scoreboard for the value
  task automatic sweep_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    in_valid = 1'b1; alu_control = op; r1 = a; r2 = b;
    #1;
    lat = 0;
    while (!in_ready && lat < 100) begin @(negedge clk); #1; lat++; end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    if (lat >= 100) begin
      checks++; errors++;
      $display("FAIL sweep_timeout: op %0d got no result expected one within 100 cycles", op);
    end
  endtask

  logic [31:0] sw_a[4] = '{32'h7FFF_FFFF, 32'hDEAD_BEEF, 32'h8000_0001, 32'h1234_5678};
  logic [31:0] sw_b[4] = '{32'h0000_0003, 32'h0000_001F, 32'hFFFF_FFFE, 32'h0000_0000};

  initial begin
    logic seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    r1 = '0; r2 = '0; alu_control = '0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", alu_result, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back single-cycle ops
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; alu_control = 4'd0; r1 = 32'd30; r2 = 32'd15;
    #1 check("b2b_add_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("b2b_add_valid", {31'd0, out_valid}, 32'd1);
    check("b2b_add", alu_result, 32'd45);
    alu_control = 4'd1; r1 = 32'd16; r2 = 32'd1;
    #1 check("b2b_sll_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("b2b_sll", alu_result, 32'd32);
    alu_control = 4'd2; r1 = 32'd15; r2 = 32'd30;
    #1 check("b2b_slt_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("b2b_slt", alu_result, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);

    // Directed vectors with hand-computed results
    run_op("sra",   4'd9,  32'h8000_0000, 32'd4,         32'hF800_0000, 1);
    run_op("srl",   4'd5,  32'h8000_0000, 32'd4,         32'h0800_0000, 1);
    run_op("sub",   4'd8,  32'd15,        32'd30,        32'hFFFF_FFF1, 1);
    run_op("sltu",  4'd3,  32'd1,         32'hFFFF_FFFF, 32'd1,         1);
    run_op("mul",   4'd10, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33);
    run_op("mulhu", 4'd11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33);
    run_op("div",   4'd12, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    run_op("rem",   4'd14, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    run_op("divov", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_op("remov", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("divu0", 4'd13, 32'd10,        32'd0,         32'hFFFF_FFFF, 1);
    run_op("remu0", 4'd15, 32'd10,        32'd0,         32'd10,        1);
    run_op("divu",  4'd13, 32'd100,       32'd7,         32'd14,        33);
    run_op("remu",  4'd15, 32'd100,       32'd7,         32'd2,         33);

    // Every opcode over a few operand pairs, checked by the scoreboard
    for (int op = 0; op < 16; op++)
      for (int k = 0; k < 4; k++)
        sweep_op(4'(op), sw_a[k], sw_b[k]);
    @(negedge clk);

    // Back-pressure
    out_ready = 1'b0;
    in_valid = 1'b1; alu_control = 4'd0; r1 = 32'd1; r2 = 32'd2;
    #1 check("bp_first_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    alu_control = 4'd4; r1 = 32'd5; r2 = 32'd3;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_result", alu_result, 32'd3);
      check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);
    check("bp_next_result", alu_result, 32'd6);
    @(negedge clk);

    // Flush during a DIVU
    in_valid = 1'b1; alu_control = 4'd13; r1 = 32'd1000; r2 = 32'd3;
    #1 check("fl_accept_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("fl_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    in_valid = 1'b1; alu_control = 4'd0; r1 = 32'd1; r2 = 32'd1;
    #1 check("fl_cycle_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("fl_busy", {31'd0, busy}, 32'd0);
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_in_ready", {31'd0, in_ready}, 32'd1);
    check("fl_result_kept", alu_result, 32'd6);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    check("fl_no_result", {31'd0, seen}, 32'd0);

    // Asynchronous reset mid-BUSY
    in_valid = 1'b1; alu_control = 4'd11; r1 = 32'hFFFF_FFFF; r2 = 32'hFFFF_FFFF;
    #1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("ar_busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check("ar_result", alu_result, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 check("ar_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    run_op("post_rst_add", 4'd0, 32'd7, 32'd8, 32'd15, 1);
    @(negedge clk); @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected completion before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
